// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MD op codes, FSM encoding and default latencies (MDU_MADD_EN widens op)
package mdu_pkg;

`ifdef MDU_MADD_EN
  localparam int OP_W = 4;
`else
  localparam int OP_W = 3;
`endif

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NONE  = op_t'(0);
  localparam op_t OP_MULT  = op_t'(1);
  localparam op_t OP_MULTU = op_t'(2);
  localparam op_t OP_DIV   = op_t'(3);
  localparam op_t OP_DIVU  = op_t'(4);
  localparam op_t OP_MTHI  = op_t'(5);
  localparam op_t OP_MTLO  = op_t'(6);
`ifdef MDU_MADD_EN
  localparam op_t OP_MADD  = op_t'(7);
  localparam op_t OP_MADDU = op_t'(8);
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Multiply-family ops share the multiply latency.
  function automatic logic is_mul(op_t op);
`ifdef MDU_MADD_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MADDU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  function automatic logic is_div(op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// rtl/ex_mdu_if.sv - EX-stage MDU operand/result bundle with pipeline and MDU views
interface ex_mdu_if;
  import mdu_pkg::*;

  logic        start;
  op_t         op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rs_data, rt_data, input busy, hi, lo);
  modport slave  (input start, op, rs_data, rt_data, output busy, hi, lo);
endinterface

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational 32x32 multiply / divide producing {hi,lo}
module mdu_calc
  import mdu_pkg::*;
(
  input  op_t         op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [63:0] result_o,
  output logic        div_by_zero_o
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] s_rs;
  logic signed [31:0] s_rt;
  logic signed [31:0] s_quo;
  logic signed [31:0] s_rem;

  assign prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
  assign prod_u = {32'b0, rs_i} * {32'b0, rt_i};
  assign s_rs   = $signed(rs_i);
  assign s_rt   = $signed(rt_i);

  // Result select; divide-by-zero and the signed overflow pair are handled explicitly.
  always_comb begin
    result_o      = 64'b0;
    div_by_zero_o = 1'b0;
    s_quo         = 32'sd0;
    s_rem         = 32'sd0;
    case (op_i)
      OP_MULT:  result_o = prod_s;
      OP_MULTU: result_o = prod_u;
`ifdef MDU_MADD_EN
      OP_MADD:  result_o = prod_s;
      OP_MADDU: result_o = prod_u;
`endif
      OP_DIV: begin
        if (rt_i == 32'b0) begin
          div_by_zero_o = 1'b1;
        end else if (rs_i == 32'h8000_0000 && rt_i == 32'hFFFF_FFFF) begin
          result_o = {32'b0, 32'h8000_0000};
        end else begin
          s_quo    = s_rs / s_rt;
          s_rem    = s_rs % s_rt;
          result_o = {s_rem, s_quo};
        end
      end
      OP_DIVU: begin
        if (rt_i == 32'b0) begin
          div_by_zero_o = 1'b1;
        end else begin
          result_o = {rs_i % rt_i, rs_i / rt_i};
        end
      end
      default: result_o = 64'b0;
    endcase
  end

endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - iterative-latency MDU owning HI/LO; MDU_MADD_EN adds MADD/MADDU
module ex_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  ex_mdu_if.slave   mdu
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_dz_q;
  logic        pend_acc_q;
  logic [31:0] hi_q, lo_q;

  logic [63:0] calc_result;
  logic        calc_dz;
  logic        accept_long;
  logic        done;

  mdu_calc u_calc (
    .op_i          (mdu.op),
    .rs_i          (mdu.rs_data),
    .rt_i          (mdu.rt_data),
    .result_o      (calc_result),
    .div_by_zero_o (calc_dz)
  );

  assign accept_long = (state_q == ST_IDLE) && mdu.start && (is_mul(mdu.op) || is_div(mdu.op));
  assign done        = (state_q == ST_BUSY) && (cnt_q == 4'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: leave IDLE on a multi-cycle op, return when the counter expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_long) state_d = ST_BUSY;
      ST_BUSY: if (done)        state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: busy follows the state, hi/lo come straight from registers.
  always_comb begin
    mdu.busy = (state_q == ST_BUSY);
    mdu.hi   = hi_q;
    mdu.lo   = lo_q;
  end

  // Datapath: capture pending result on accept, commit it at completion, MTHI/MTLO when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 4'd0;
      pend_hi_q  <= 32'b0;
      pend_lo_q  <= 32'b0;
      pend_dz_q  <= 1'b0;
      pend_acc_q <= 1'b0;
      hi_q       <= 32'b0;
      lo_q       <= 32'b0;
    end else if (accept_long) begin
      cnt_q     <= is_div(mdu.op) ? DIV_LAT : MULT_LAT;
      pend_hi_q <= calc_result[63:32];
      pend_lo_q <= calc_result[31:0];
      pend_dz_q <= calc_dz;
`ifdef MDU_MADD_EN
      pend_acc_q <= (mdu.op == OP_MADD) || (mdu.op == OP_MADDU);
`else
      pend_acc_q <= 1'b0;
`endif
    end else if (state_q == ST_BUSY) begin
      cnt_q <= cnt_q - 4'd1;
      if (done && !pend_dz_q) begin
        // Accumulate against hi/lo as they stand now, not at accept time.
        if (pend_acc_q) {hi_q, lo_q} <= {hi_q, lo_q} + {pend_hi_q, pend_lo_q};
        else            {hi_q, lo_q} <= {pend_hi_q, pend_lo_q};
      end
    end else if (mdu.start) begin
      if (mdu.op == OP_MTHI) hi_q <= mdu.rs_data;
      if (mdu.op == OP_MTLO) lo_q <= mdu.rs_data;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - randomized self-checking bench for ex_mdu against an arithmetic model
module tb_ex_mdu;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_mdu_if bus ();

  ex_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_hi, exp_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lat(op_t c);
    case (c)
      OP_MULT, OP_MULTU: return MULT_N;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: return MULT_N;
`endif
      OP_DIV, OP_DIVU:   return DIV_N;
      default:           return 0;
    endcase
  endfunction

  // Architectural effect of one completed op on HI/LO.
  function automatic void model(op_t c, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p, qq, rr;
    sa = $signed(a);
    sb = $signed(b);
    case (c)
      OP_MULT:  begin p = sa * sb; {exp_hi, exp_lo} = p; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {exp_hi, exp_lo} = p; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin p = sa * sb; {exp_hi, exp_lo} = {exp_hi, exp_lo} + p; end
      OP_MADDU: begin p = {32'b0, a} * {32'b0, b}; {exp_hi, exp_lo} = {exp_hi, exp_lo} + p; end
`endif
      OP_DIV: if (b != 0) begin
        q = sa / sb; r = sa % sb; qq = q; rr = r;
        exp_lo = qq[31:0]; exp_hi = rr[31:0];
      end
      OP_DIVU: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      OP_MTHI: exp_hi = a;
      OP_MTLO: exp_lo = a;
      default: ;
    endcase
  endfunction

  // Issue one op; optionally inject an MTHI start on busy cycle 'intrude' or reset on 'rst_at'.
  task automatic do_op(input op_t code, input logic [31:0] a, input logic [31:0] b,
                       input int intrude, input int rst_at);
    int n;
    n = lat(code);
    @(negedge clk);
    bus.start = 1'b1; bus.op = code; bus.rs_data = a; bus.rt_data = b;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == intrude) begin
        bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_data = 32'h0000_DEAD;
      end else begin
        bus.start = 1'b0;
      end
      check("busy_high", {63'b0, bus.busy}, 64'd1);
      check("hold_hilo", {bus.hi, bus.lo}, {exp_hi, exp_lo});
      if (i == rst_at) begin
        reset = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'b0; exp_lo = 32'b0;
        check("abort_busy", {63'b0, bus.busy}, 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        return;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    model(code, a, b);
    check("done_busy", {63'b0, bus.busy}, 64'd0);
    check("done_hilo", {bus.hi, bus.lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    op_t         code;
    logic [31:0] a, b;
    int          sel;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = OP_NONE; bus.rs_data = 32'b0; bus.rt_data = 32'b0;
    exp_hi = 32'b0; exp_lo = 32'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_hi", {32'b0, bus.hi}, 64'd0);
    check("rst_lo", {32'b0, bus.lo}, 64'd0);
    reset = 1'b0;

    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
    check("mult_neg", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});

    do_op(OP_DIVU, 32'd100, 32'd7, 0, 0);
    check("divu_100_7", {bus.hi, bus.lo}, {32'd2, 32'd14});

    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("div_neg7_2", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    do_op(OP_DIV, 32'd55, 32'd0, 0, 0);
    check("div_by_zero", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("div_ovf", {bus.hi, bus.lo}, {32'h0, 32'h8000_0000});

    // MTHI then MTLO on consecutive cycles; busy must stay low.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_data = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", {32'b0, bus.hi}, {32'b0, 32'h1234_5678});
    check("mthi_busy", {63'b0, bus.busy}, 64'd0);
    bus.op = OP_MTLO; bus.rs_data = 32'hCAFE_BABE;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_lo", {32'b0, bus.lo}, {32'b0, 32'hCAFE_BABE});
    check("mtlo_busy", {63'b0, bus.busy}, 64'd0);
    exp_hi = 32'h1234_5678; exp_lo = 32'hCAFE_BABE;

    do_op(OP_MULT, 32'd7, 32'hFFFF_FFF0, 2, 0);
    check("mult_intrude", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FF90});

    do_op(OP_DIV, 32'd1000, 32'd3, 0, 3);

    do_op(OP_NONE, 32'h1111_1111, 32'h2222_2222, 0, 0);
`ifndef MDU_MADD_EN
    do_op(op_t'(7), 32'h3333_3333, 32'h4444_4444, 0, 0);
`else
    do_op(OP_MTHI, 32'd0, 32'd0, 0, 0);
    do_op(OP_MTLO, 32'd10, 32'd0, 0, 0);
    do_op(OP_MADD, 32'd4, 32'd5, 0, 0);
    check("madd_acc", {bus.hi, bus.lo}, {32'd0, 32'd30});
`endif

    for (int k = 0; k < 40; k++) begin
`ifdef MDU_MADD_EN
      code = op_t'($urandom_range(0, 8));
`else
      code = op_t'($urandom_range(0, 7));
`endif
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        2:       begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        default: b = $urandom;
      endcase
      do_op(code, a, b, (sel == 3) ? $urandom_range(1, 4) : 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
